change_dispense_ctrl: RTL

Sequences the coin-return mechanism after a vend or cancel. Takes a change amount in cents from the transaction FSM and breaks it greedily into 50/25/10/5-cent coins. Issues one eject request per coin over a req/ack handshake, with a mechanical settle gap between coins. Sits between the vending FSM (start/done) and the physical ejector driver.

---
 rtl/change_dispense_ctrl.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/change_dispense_ctrl.sv
// -----------------------------------------------------------------------------
// change_dispense_ctrl
//
// Purpose:
//   Coin-return sequencer. After a vend or cancel, the transaction FSM hands
//   over a change amount in cents. This block breaks it greedily into
//   50/25/10/5-cent coins. It issues one eject request per coin to the ejector
//   driver over a req/ack handshake, and leaves a mechanical settle gap
//   between coins.
//
// Optional feature (compile-time macro):
//   ACK_TIMEOUT_EN - when defined, a watchdog aborts a request that stays
//                    unacknowledged for ACK_TIMEOUT cycles and ends the
//                    transaction in FAULT. When undefined, REQ waits
//                    indefinitely and no watchdog logic is built.
//
// Parameters:
//   AMT_W       - width of the change amount and remaining counter (>= 6)
//   GAP_CYCLES  - idle cycles between ack and next coin selection (>= 1)
//   ACK_TIMEOUT - unacknowledged REQ cycles before abort (ACK_TIMEOUT_EN only)
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   start      in   one-cycle dispense request, accepted only in IDLE
//   change_amt in   change in cents, sampled on an accepted start
//   busy       out  high from the cycle after accept until DONE/FAULT exit
//   done       out  one-cycle pulse, all change dispensed
//   fault      out  sticky error, cleared by the next accepted start or reset
//   eject_req  out  coin eject request
//   eject_coin out  coin code while eject_req: 00=50c 01=25c 10=10c 11=5c
//   eject_ack  in   ejector acknowledge, only meaningful while eject_req=1
//   remaining  out  cents still to dispense
//   coin_count out  coins ejected this transaction, saturating at 15
// -----------------------------------------------------------------------------
module change_dispense_ctrl #(
    parameter int AMT_W       = 8,
    parameter int GAP_CYCLES  = 4,
    parameter int ACK_TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AMT_W-1:0] change_amt,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic             eject_req,
    output logic [1:0]       eject_coin,
    input  logic             eject_ack,
    output logic [AMT_W-1:0] remaining,
    output logic [3:0]       coin_count
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_REQ    = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    // Elaboration-time sanity check of the configuration.
    if (GAP_CYCLES < 1 || ACK_TIMEOUT < 1 || AMT_W < 6) begin : g_param_check
        $error("change_dispense_ctrl: illegal parameter combination");
    end

    // Cent value of a coin code.
    function automatic logic [AMT_W-1:0] coin_value(input logic [1:0] code);
        logic [AMT_W-1:0] val;
        case (code)
            2'b00:   val = AMT_W'(7'd50);
            2'b01:   val = AMT_W'(7'd25);
            2'b10:   val = AMT_W'(7'd10);
            2'b11:   val = AMT_W'(7'd5);
            default: val = AMT_W'(7'd0);
        endcase
        return val;
    endfunction

    state_t           state_q, state_d;
    logic [AMT_W-1:0] rem_q,   rem_d;
    logic [3:0]       cnt_q,   cnt_d;
    logic [1:0]       coin_q,  coin_d;
    logic [GAP_W-1:0] gap_q,   gap_d;
    logic             req_q,   req_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic             fault_q, fault_d;

`ifdef ACK_TIMEOUT_EN
    localparam int WD_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(ACK_TIMEOUT - 1);
    logic [WD_W-1:0]  wd_q, wd_d;
`endif

    // Next-state logic plus the next values of the registered outputs.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        coin_d  = coin_q;
        gap_d   = gap_q;
`ifdef ACK_TIMEOUT_EN
        wd_d    = wd_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SELECT;
                    rem_d   = change_amt;
                    cnt_d   = 4'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SELECT: begin
                // Largest coin that still fits; a 1..4 cent residual cannot be paid.
                if (rem_q >= AMT_W'(7'd50)) begin
                    coin_d  = 2'b00;
                    state_d = ST_REQ;
                end else if (rem_q >= AMT_W'(7'd25)) begin
                    coin_d  = 2'b01;
                    state_d = ST_REQ;
                end else if (rem_q >= AMT_W'(7'd10)) begin
                    coin_d  = 2'b10;
                    state_d = ST_REQ;
                end else if (rem_q >= AMT_W'(7'd5)) begin
                    coin_d  = 2'b11;
                    state_d = ST_REQ;
                end else if (rem_q == AMT_W'(7'd0)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_FAULT;
                end
`ifdef ACK_TIMEOUT_EN
                wd_d = WD_W'(1'b0);
`endif
            end
            ST_REQ: begin
                if (eject_ack) begin
                    rem_d   = rem_q - coin_value(coin_q);
                    cnt_d   = (cnt_q == 4'd15) ? 4'd15 : cnt_q + 4'd1;
                    gap_d   = GAP_W'(1'b0);
                    state_d = ST_GAP;
`ifdef ACK_TIMEOUT_EN
                end else if (wd_q == WD_LAST) begin
                    // Abandon the coin; remaining and coin_count keep their values.
                    state_d = ST_FAULT;
                end else begin
                    wd_d    = wd_q + WD_W'(1'b1);
                    state_d = ST_REQ;
`else
                end else begin
                    state_d = ST_REQ;
`endif
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = GAP_W'(1'b0);
                    state_d = ST_SELECT;
                end else begin
                    gap_d   = gap_q + GAP_W'(1'b1);
                    state_d = ST_GAP;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_FAULT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Outputs are registered copies decoded from the next state, so they
        // line up with the state they describe.
        req_d  = (state_d == ST_REQ);
        busy_d = (state_d == ST_SELECT) || (state_d == ST_REQ) || (state_d == ST_GAP);
        done_d = (state_d == ST_DONE);

        // fault is sticky across IDLE until the next accepted start.
        if (state_d == ST_FAULT) begin
            fault_d = 1'b1;
        end else if ((state_q == ST_IDLE) && start) begin
            fault_d = 1'b0;
        end else begin
            fault_d = fault_q;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rem_q   <= AMT_W'(1'b0);
            cnt_q   <= 4'd0;
            coin_q  <= 2'b00;
            gap_q   <= GAP_W'(1'b0);
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
`ifdef ACK_TIMEOUT_EN
            wd_q    <= WD_W'(1'b0);
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            coin_q  <= coin_d;
            gap_q   <= gap_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fault_q <= fault_d;
`ifdef ACK_TIMEOUT_EN
            wd_q    <= wd_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign fault      = fault_q;
    assign eject_req  = req_q;
    assign eject_coin = coin_q;
    assign remaining  = rem_q;
    assign coin_count = cnt_q;

endmodule
